bg_fetch_sequencer: RTL
=======================

BG_FETCH_SEQUENCER -- requirements
Module: bg_fetch_sequencer

Interface
REQ-001 SHALL have parameter TILES, default 40, meaning visible tiles per line.
REQ-002 SHALL have parameter PAN_W, default 3, meaning pan width; PIX = 2^PAN_W pixels per tile.
REQ-003 SHALL have parameter CYCLES_PER_TILE (CPT), default 12, meaning clocks per tile slot; legal only if CPT >= 6 and CPT >= PIX.
REQ-004 SHALL have parameter TIDX_W, default 7, meaning tile-index width; legal only if 2^TIDX_W > TILES.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port lineStarting, input, 1 bit: start-of-line pulse.
REQ-008 SHALL have port panOffset, input, PAN_W bits: fine horizontal pan, sampled only at lineStarting.
REQ-009 SHALL have strobe outputs, 1 bit each: charAddrOut, charDataIn, palAddrOut, palDataIn, tileLowAddrOut, tileLowDataIn, tileHighAddrOut, tileHighDataIn.
REQ-010 SHALL have outputs pixelOut and pixelMask, 1 bit each: pixel-slot valid and pixel-visible.
REQ-011 SHALL have output tileIndex, TIDX_W bits: index of the tile currently being fetched.
REQ-012 SHALL have outputs busy and lineDone, 1 bit each: sequencer live, and one-cycle end-of-line pulse.

Function
REQ-013 SHALL hold a phase counter P in 0..CPT-1 and a tile counter T; all outputs SHALL be registered or decoded from registered state only.
REQ-014 lineStarting at edge k SHALL latch panOffset into panReg, set N = TILES + (panReg != 0), set T=0, P=0 and busy=1, so phase 0 of tile 0 appears in cycle k+1.
REQ-015 While busy, P SHALL increment each clock; at P=CPT-1, P SHALL wrap to 0 and T SHALL increment.
REQ-016 Strobe decode while busy: P=0 charAddrOut; P=1 charDataIn and palAddrOut; P=2 tileLowAddrOut; P=3 palDataIn and tileLowDataIn; P=4 tileHighAddrOut; P=5 tileHighDataIn.
REQ-017 pixelOut SHALL be 1 while busy and P >= CPT-PIX; the pixel number is q = P-(CPT-PIX), in the range 0..PIX-1.
REQ-018 pixelMask SHALL be pixelOut AND visible(q), where: T=0 gives q >= panReg; T=TILES (extra tile) gives q < panReg; otherwise visible.
REQ-019 tileIndex SHALL equal T while busy, and SHALL hold its last value while idle.
REQ-020 At T=N-1 and P=CPT-1, busy SHALL clear on the next edge, and no strobe for tile N SHALL ever assert.
REQ-021 lineDone SHALL be 1 for exactly the cycle after the last pixel slot.
REQ-022 lineStarting while busy SHALL abort the current line and restart per REQ-014; no lineDone SHALL be issued for the aborted line.
REQ-023 lineStarting coincident with the lineDone-generating edge SHALL restart the line and still pulse lineDone once.
REQ-024 All outputs SHALL be 0 whenever busy=0, except tileIndex and lineDone.

Reset
REQ-025 reset SHALL take priority over lineStarting.
REQ-026 reset=1 SHALL set busy=0, P=0, T=0, panReg=0, tileIndex=0, lineDone=0 and all strobes and pixel outputs to 0 on the next edge, including when asserted mid-line.
REQ-027 After reset, outputs SHALL stay 0 until the first lineStarting.

Verification
REQ-028 Defaults, pan=0, lineStarting at cycle 0 -> cycles 1..480 busy; charAddrOut at cycles 1, 13, ..., 469; pixelMask count = 320; lineDone at cycle 481; tileIndex max = 39.
REQ-029 Defaults, pan=3 -> 41 tiles, busy for 492 cycles; tile 0 pixelMask pattern 00011111; tile 40 pattern 11100000; pixelMask total = 320; pixelOut total = 328.
REQ-030 Restart at cycle 100 of a line -> P=0, T=0 at cycle 101; exactly one lineDone, for the new line only.
REQ-031 reset at cycle 50 mid-line -> all outputs 0 at cycle 51; idle until the next lineStarting; reset and lineStarting together -> idle.
REQ-032 Run with TILES=4, PAN_W=2, CPT=6, pan=1 -> 5 tiles, 30 busy cycles; pixel slots at P=2..5; tile 0 mask 0111; tile 4 mask 1000.
REQ-033 Change panOffset mid-line -> pixelMask for the current line is unaffected.

Source files
------------

// File: rtl/bg_fetch_sequencer.sv
// Background tile fetch sequencer: steps a phase/tile counter pair across a line,
// decodes per-phase memory strobes and flags pixel slots with fine-pan visibility.
module bg_fetch_sequencer #(
   parameter int TILES           = 40,
   parameter int PAN_W           = 3,
   parameter int CYCLES_PER_TILE = 12,
   parameter int TIDX_W          = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lineStarting,
   input  logic [PAN_W-1:0]  panOffset,
   output logic              charAddrOut,
   output logic              charDataIn,
   output logic              palAddrOut,
   output logic              palDataIn,
   output logic              tileLowAddrOut,
   output logic              tileLowDataIn,
   output logic              tileHighAddrOut,
   output logic              tileHighDataIn,
   output logic              pixelOut,
   output logic              pixelMask,
   output logic [TIDX_W-1:0] tileIndex,
   output logic              busy,
   output logic              lineDone
);

   localparam int PIX       = 1 << PAN_W;
   localparam int CPT       = CYCLES_PER_TILE;
   localparam int P_W       = $clog2(CPT);
   localparam int PIX_START = CPT - PIX;
   localparam int CMP_W     = ((P_W > PAN_W) ? P_W : PAN_W) + 1;

   localparam logic [P_W-1:0]    PHASE_LAST = P_W'(CPT - 1);
   localparam logic [P_W-1:0]    PHASE_PIX  = P_W'(PIX_START);
   localparam logic [TIDX_W-1:0] TILE_EXTRA = TIDX_W'(TILES);
   localparam logic [TIDX_W-1:0] TILE_LAST  = TIDX_W'(TILES - 1);

   logic              busy_reg;
   logic [P_W-1:0]    phase_reg;
   logic [TIDX_W-1:0] tile_reg;
   logic [TIDX_W-1:0] last_tile_reg;
   logic [PAN_W-1:0]  pan_reg;
   logic              line_done_reg;

   logic              end_of_line;
   logic [5:0]        phase_hit;
   logic              pix_slot;
   logic [P_W-1:0]    pix_num;
   logic [CMP_W-1:0]  pix_num_ext;
   logic [CMP_W-1:0]  pan_ext;
   logic              visible;

   assign end_of_line = busy_reg && (phase_reg == PHASE_LAST) && (tile_reg == last_tile_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_reg      <= 1'b0;
         phase_reg     <= '0;
         tile_reg      <= '0;
         last_tile_reg <= '0;
         pan_reg       <= '0;
         line_done_reg <= 1'b0;
      end else begin
         // The pulse is issued even when a new line starts on the same edge.
         line_done_reg <= end_of_line;
         if (lineStarting) begin
            busy_reg      <= 1'b1;
            phase_reg     <= '0;
            tile_reg      <= '0;
            pan_reg       <= panOffset;
            last_tile_reg <= (panOffset != '0) ? TILE_EXTRA : TILE_LAST;
         end else if (busy_reg) begin
            if (phase_reg == PHASE_LAST) begin
               phase_reg <= '0;
               // Tile counter parks on the last tile so tileIndex holds while idle.
               if (tile_reg == last_tile_reg) begin
                  busy_reg <= 1'b0;
               end else begin
                  tile_reg <= tile_reg + 1'b1;
               end
            end else begin
               phase_reg <= phase_reg + 1'b1;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_phase
         assign phase_hit[gi] = busy_reg && (phase_reg == P_W'(gi));
      end
   endgenerate

   assign charAddrOut     = phase_hit[0];
   assign charDataIn      = phase_hit[1];
   assign palAddrOut      = phase_hit[1];
   assign tileLowAddrOut  = phase_hit[2];
   assign palDataIn       = phase_hit[3];
   assign tileLowDataIn   = phase_hit[3];
   assign tileHighAddrOut = phase_hit[4];
   assign tileHighDataIn  = phase_hit[5];

   assign pix_slot    = busy_reg && (phase_reg >= PHASE_PIX);
   assign pix_num     = phase_reg - PHASE_PIX;
   assign pix_num_ext = CMP_W'(pix_num);
   assign pan_ext     = CMP_W'(pan_reg);

   // First tile hides the leading pan pixels; the extra tile shows only them.
   always_comb begin
      visible = 1'b1;
      if (tile_reg == '0) begin
         visible = (pix_num_ext >= pan_ext);
      end else if (tile_reg == TILE_EXTRA) begin
         visible = (pix_num_ext < pan_ext);
      end
   end

   assign pixelOut  = pix_slot;
   assign pixelMask = pix_slot && visible;
   assign tileIndex = tile_reg;
   assign busy      = busy_reg;
   assign lineDone  = line_done_reg;

endmodule
